// File: rtl/controle_rolagem_if.sv
// ---------------------------------------------------------------------------
// controle_rolagem_if
// Signal bundle between the sign front panel (switches and key) and the
// scroll controller.
//   speed  [1:0] scroll period select, period = BASE_TICKS << speed
//   dir          0 = position increments, 1 = position decrements
//   pause        1 = automatic scrolling halted, single-step enabled
//   step_n       raw push-button, active-low, asynchronous
//   pos    [2:0] current scroll position
//   tick         one-cycle pulse, high in the cycle pos takes its new value
//   paused       registered copy of pause
// There is no valid/ready handshake on this bundle: tick is a pure
// qualifier. It is high for exactly one cycle together with the new pos,
// and the consumer has no way to stall it.
// master = panel side (drives the controls), slave = scroll controller.
// ---------------------------------------------------------------------------
interface controle_rolagem_if;
   logic [1:0] speed;
   logic       dir;
   logic       pause;
   logic       step_n;
   logic [2:0] pos;
   logic       tick;
   logic       paused;

   modport master (output speed, dir, pause, step_n,
                   input  pos, tick, paused);
   modport slave  (input  speed, dir, pause, step_n,
                   output pos, tick, paused);
endinterface

// File: rtl/controle_rolagem.sv
// ---------------------------------------------------------------------------
// controle_rolagem
// Scroll controller for the 8-digit HEX sign. It produces the 3-bit scroll
// position from a clock-enable prescaler. It supports selectable speed,
// scroll direction, pause, and single-step from a debounced push-button.
// All logic runs on CLOCK_50; no derived clocks.
// Ports:
//   CLOCK_50  system clock, rising edge
//   reset     asynchronous, active-low reset
//   bus       controle_rolagem_if.slave (speed, dir, pause, step_n in;
//             pos, tick, paused out)
// ---------------------------------------------------------------------------
module controle_rolagem #(
   parameter int unsigned BASE_TICKS      = 12500000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned POS_MAX         = 7
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   controle_rolagem_if.slave bus
);
   // The prescaler must hold the longest period, BASE_TICKS << 3.
   localparam int unsigned   PW       = $clog2(BASE_TICKS * 8 + 1);
   localparam int unsigned   DW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [2:0]    POS_LAST = 3'(POS_MAX);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [PW-1:0] presc_q, presc_d, period_last;
   logic [1:0]    speed_q;
   logic          speed_chg, presc_done, auto_adv, step_hon, adv;
   logic [2:0]    pos_q, pos_d;
   logic          tick_q, paused_q;
   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d, deb_prev_q;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          step_q, step_d;

   always_comb begin
      period_last = PW'((BASE_TICKS << speed_q) - 32'd1);
      speed_chg   = (bus.speed != speed_q);
      presc_done  = (presc_q == period_last);

      // Pause and a speed change both restart the period. A speed change
      // on the terminal-count cycle suppresses that cycle's advance.
      auto_adv = !bus.pause && !speed_chg && presc_done;
      if (bus.pause || speed_chg || presc_done) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end

      // Step events are only meaningful while paused. Otherwise they are
      // dropped, because step_q lasts a single cycle.
      step_hon = step_q && bus.pause;
      adv      = auto_adv || step_hon;

      pos_d = pos_q;
      if (adv) begin
         if (bus.dir) begin
            pos_d = (pos_q == 3'd0) ? POS_LAST : pos_q - 3'd1;
         end else begin
            pos_d = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
         end
      end

      // Debouncer: accept a new level only after it has differed from the
      // accepted level for DEBOUNCE_CYCLES consecutive cycles.
      deb_d  = deb_q;
      dcnt_d = '0;
      if (sync2_q != deb_q) begin
         if (dcnt_q == DEB_LAST) begin
            deb_d = sync2_q;
         end else begin
            dcnt_d = dcnt_q + DW'(1);
         end
      end

      // Press = falling edge of the debounced level.
      step_d = deb_prev_q && !deb_q;
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         presc_q    <= '0;
         speed_q    <= 2'd0;
         pos_q      <= 3'd0;
         tick_q     <= 1'b0;
         paused_q   <= 1'b0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         deb_q      <= 1'b1;
         deb_prev_q <= 1'b1;
         dcnt_q     <= '0;
         step_q     <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         speed_q    <= bus.speed;
         pos_q      <= pos_d;
         tick_q     <= adv;
         paused_q   <= bus.pause;
         sync1_q    <= bus.step_n;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         dcnt_q     <= dcnt_d;
         step_q     <= step_d;
      end
   end

   assign bus.pos    = pos_q;
   assign bus.tick   = tick_q;
   assign bus.paused = paused_q;

endmodule

// File: tb/tb_controle_rolagem.sv
// ---------------------------------------------------------------------------
// tb_controle_rolagem
// Self-checking bench for controle_rolagem with short periods
// (BASE_TICKS=4, DEBOUNCE_CYCLES=8). A behavioural model tracks when the
// scroll period restarts, the debounced key level as a run length, and
// pending step events as absolute cycle numbers.
// ---------------------------------------------------------------------------
module tb_controle_rolagem;
   localparam int BT = 4;
   localparam int DB = 8;
   localparam int PM = 7;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   controle_rolagem_if bus_if ();

   controle_rolagem #(
      .BASE_TICKS      (BT),
      .DEBOUNCE_CYCLES (DB),
      .POS_MAX         (PM)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (rst_n),
      .bus      (bus_if.slave)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   int         m_n;        // clock edges since reset release
   int         m_start;    // edge at which the current period began
   logic [1:0] m_speed;
   logic [2:0] m_pos;
   logic       m_tick, m_paused;
   logic [1:0] m_hist;     // [0]=step_n one edge ago, [1]=two edges ago
   logic       m_deb;
   int         m_run;
   int         step_at[$]; // edges at which a press reaches pos
   logic [2:0] exp_q[$];   // scoreboard: expected pos at each tick

   task automatic model_reset();
      m_n = 0; m_start = 0; m_speed = 2'd0; m_pos = 3'd0;
      m_tick = 1'b0; m_paused = 1'b0; m_hist = 2'b11; m_deb = 1'b1;
      m_run = 0; step_at.delete(); exp_q.delete();
   endtask

   task automatic model_edge();
      logic hon, adv, seen;
      int   per;
      m_n++;
      per = BT << m_speed;
      hon = 1'b0;
      if (step_at.size() > 0 && step_at[0] == m_n) begin
         hon = bus_if.pause;
         void'(step_at.pop_front());
      end
      adv = 1'b0;
      if (bus_if.pause || bus_if.speed != m_speed) m_start = m_n;
      else if (m_n - m_start == per) begin
         adv = 1'b1;
         m_start = m_n;
      end
      m_speed = bus_if.speed;
      adv = adv | hon;
      if (adv) begin
         m_pos = 3'((int'(m_pos) + (bus_if.dir ? PM : 1)) % (PM + 1));
         exp_q.push_back(m_pos);
      end
      m_tick   = adv;
      m_paused = bus_if.pause;
      seen = m_hist[1];
      m_hist = {m_hist[0], bus_if.step_n};
      if (seen != m_deb) begin
         m_run++;
         if (m_run == DB) begin
            m_deb = seen;
            m_run = 0;
            if (!m_deb) step_at.push_back(m_n + 2);
         end
      end else begin
         m_run = 0;
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change just after the falling edge; outputs are read at it.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus_if.speed = 2'd0; bus_if.dir = 1'b0; bus_if.pause = 1'b1;
      bus_if.step_n = 1'b1;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (bus_if.pos !== 3'd0 || bus_if.tick !== 1'b0 || bus_if.paused !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pos=%0d tick=%0b paused=%0b, expected 0 0 0",
                  bus_if.pos, bus_if.tick, bus_if.paused);
      end
      bus_if.pause = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_free_run();
      int nt = 0;
      logic [2:0] got;
      for (int i = 1; i <= 32; i++) begin
         cycle();
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick || bus_if.paused !== m_paused) begin
            errors++;
            $display("FAIL free_run_model cyc %0d: pos=%0d tick=%0b paused=%0b, expected %0d %0b %0b",
                     i, bus_if.pos, bus_if.tick, bus_if.paused, m_pos, m_tick, m_paused);
         end
         checks++;
         if (bus_if.tick !== (i % 4 == 0)) begin
            errors++;
            $display("FAIL free_run_tick cyc %0d: tick=%0b, expected %0b", i, bus_if.tick, (i % 4 == 0));
         end
         if (bus_if.tick === 1'b1) begin
            nt++;
            got = 3'(nt % 8);
            checks++;
            if (bus_if.pos !== got) begin
               errors++;
               $display("FAIL free_run_pos tick %0d: pos=%0d, expected %0d", nt, bus_if.pos, got);
            end
            if (exp_q.size() > 0) begin
               got = exp_q.pop_front();
               checks++;
               if (bus_if.pos !== got) begin
                  errors++;
                  $display("FAIL free_run_sb: pos=%0d, expected %0d", bus_if.pos, got);
               end
            end
         end
      end
      checks++;
      if (nt != 8) begin
         errors++;
         $display("FAIL free_run_count: ticks=%0d, expected 8", nt);
      end
   endtask

   task automatic test_speed_dir();
      int first = 0, second = 0;
      logic [2:0] fpos = 3'd0, spos = 3'd0;
      bus_if.speed = 2'd2; bus_if.dir = 1'b1; bus_if.pause = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      // Edge 1 loads speed=2 and restarts the period; 16 cycles later pos moves.
      for (int i = 1; i <= 40; i++) begin
         cycle();
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick || bus_if.paused !== m_paused) begin
            errors++;
            $display("FAIL speed_model cyc %0d: pos=%0d tick=%0b, expected %0d %0b",
                     i, bus_if.pos, bus_if.tick, m_pos, m_tick);
         end
         if (bus_if.tick === 1'b1) begin
            if (first == 0) begin first = i; fpos = bus_if.pos; end
            else if (second == 0) begin second = i; spos = bus_if.pos; end
         end
      end
      checks++;
      if (first != 17 || fpos !== 3'd7) begin
         errors++;
         $display("FAIL speed2_first: cyc=%0d pos=%0d, expected 17 7", first, fpos);
      end
      checks++;
      if (second != 33 || spos !== 3'd6) begin
         errors++;
         $display("FAIL speed2_second: cyc=%0d pos=%0d, expected 33 6", second, spos);
      end
      // Mid-period switch to speed 0: the switch edge is cycle 1, advance 4 later.
      bus_if.speed = 2'd0;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick) begin
            errors++;
            $display("FAIL switch_model cyc %0d: pos=%0d tick=%0b, expected %0d %0b",
                     i, bus_if.pos, bus_if.tick, m_pos, m_tick);
         end
         if (bus_if.tick === 1'b1) begin first = i; break; end
      end
      checks++;
      if (first != 5) begin
         errors++;
         $display("FAIL speed_switch: advance at cyc %0d, expected 5", first);
      end
      // Speed change landing on the terminal-count cycle: no advance there.
      repeat (3) cycle();
      bus_if.speed = 2'd1;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (i == 1) begin
            checks++;
            if (bus_if.tick !== 1'b0) begin
               errors++;
               $display("FAIL clear_wins: tick=%0b, expected 0", bus_if.tick);
            end
         end
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick) begin
            errors++;
            $display("FAIL clear_model cyc %0d: pos=%0d tick=%0b, expected %0d %0b",
                     i, bus_if.pos, bus_if.tick, m_pos, m_tick);
         end
         if (bus_if.tick === 1'b1) begin first = i; break; end
      end
      checks++;
      if (first != 9) begin
         errors++;
         $display("FAIL clear_period: advance at cyc %0d, expected 9", first);
      end
   endtask

   task automatic test_step();
      int nt, first;
      logic [2:0] p1;
      bus_if.pause = 1'b1; bus_if.speed = 2'd0; bus_if.dir = 1'b0; bus_if.step_n = 1'b1;
      repeat (3) cycle();
      checks++;
      if (bus_if.paused !== 1'b1) begin
         errors++;
         $display("FAIL paused_copy: paused=%0b, expected 1", bus_if.paused);
      end
      p1 = 3'((int'(m_pos) + 1) % (PM + 1));
      nt = 0; first = 0;
      for (int i = 1; i <= DB + 20; i++) begin
         bus_if.step_n = (i <= DB + 5) ? 1'b0 : 1'b1;
         cycle();
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick) begin
            errors++;
            $display("FAIL step_model cyc %0d: pos=%0d tick=%0b, expected %0d %0b",
                     i, bus_if.pos, bus_if.tick, m_pos, m_tick);
         end
         if (bus_if.tick === 1'b1) begin nt++; if (first == 0) first = i; end
      end
      checks++;
      if (nt != 1 || first != DB + 4 || bus_if.pos !== p1) begin
         errors++;
         $display("FAIL step_press: ticks=%0d at cyc %0d pos=%0d, expected 1 at %0d pos=%0d",
                  nt, first, bus_if.pos, DB + 4, p1);
      end
      nt = 0;
      for (int i = 1; i <= 30; i++) begin
         bus_if.step_n = (i <= 5) ? 1'b0 : 1'b1;
         cycle();
         if (bus_if.tick === 1'b1) nt++;
      end
      checks++;
      if (nt != 0 || bus_if.pos !== p1) begin
         errors++;
         $display("FAIL glitch_reject: ticks=%0d pos=%0d, expected 0 ticks pos=%0d", nt, bus_if.pos, p1);
      end
   endtask

   task automatic test_step_unpaused();
      int last = 0, nt = 0;
      bus_if.pause = 1'b0; bus_if.speed = 2'd0; bus_if.dir = 1'b0; bus_if.step_n = 1'b1;
      for (int i = 1; i <= 48; i++) begin
         bus_if.step_n = (i >= 3 && i <= DB + 7) ? 1'b0 : 1'b1;
         cycle();
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick) begin
            errors++;
            $display("FAIL unpaused_model cyc %0d: pos=%0d tick=%0b, expected %0d %0b",
                     i, bus_if.pos, bus_if.tick, m_pos, m_tick);
         end
         if (bus_if.tick === 1'b1) begin
            if (last != 0) begin
               checks++;
               if (i - last != BT) begin
                  errors++;
                  $display("FAIL unpaused_gap: gap=%0d, expected %0d", i - last, BT);
               end
            end
            last = i;
         end
      end
      // Press completes while running, is held as pause rises: no advance.
      bus_if.step_n = 1'b0;
      repeat (DB + 6) cycle();
      bus_if.pause = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 21) bus_if.step_n = 1'b1;
         cycle();
         if (bus_if.tick === 1'b1) nt++;
      end
      checks++;
      if (nt != 0) begin
         errors++;
         $display("FAIL held_through_pause: ticks=%0d, expected 0", nt);
      end
      for (int i = 1; i <= DB + 20; i++) begin
         bus_if.step_n = (i <= DB + 5) ? 1'b0 : 1'b1;
         cycle();
         if (bus_if.tick === 1'b1) nt++;
      end
      checks++;
      if (nt != 1) begin
         errors++;
         $display("FAIL new_press: ticks=%0d, expected 1", nt);
      end
   endtask

   task automatic test_pause_release();
      int per, first = 0;
      logic [2:0] pexp;
      bus_if.pause = 1'b1; bus_if.dir = 1'b0; bus_if.step_n = 1'b1;
      bus_if.speed = 2'($urandom_range(0, 1));
      per = BT << bus_if.speed;
      repeat (4) cycle();
      bus_if.pause = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick || bus_if.paused !== m_paused) begin
            errors++;
            $display("FAIL unpause_model cyc %0d: pos=%0d tick=%0b paused=%0b, expected %0d %0b %0b",
                     i, bus_if.pos, bus_if.tick, bus_if.paused, m_pos, m_tick, m_paused);
         end
         if (bus_if.tick === 1'b1) begin first = i; break; end
      end
      checks++;
      if (first != per) begin
         errors++;
         $display("FAIL unpause_first: advance at cyc %0d, expected %0d", first, per);
      end
      pexp = 3'((int'(m_pos) + PM) % (PM + 1));
      for (int j = 1; j <= per; j++) begin
         if (j == per - 1) bus_if.dir = 1'b1;
         cycle();
         checks++;
         if (bus_if.tick !== (j == per)) begin
            errors++;
            $display("FAIL dir_late_tick cyc %0d: tick=%0b, expected %0b", j, bus_if.tick, (j == per));
         end
      end
      checks++;
      if (bus_if.pos !== pexp) begin
         errors++;
         $display("FAIL dir_late_pos: pos=%0d, expected %0d", bus_if.pos, pexp);
      end
   endtask

   task automatic test_reset_mid();
      int first = 0;
      bus_if.pause = 1'b0; bus_if.speed = 2'd0; bus_if.dir = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         cycle();
         if (bus_if.tick === 1'b1 && bus_if.pos === 3'd5) begin first = i; break; end
      end
      checks++;
      if (first == 0) begin
         errors++;
         $display("FAIL reach_pos5: pos=%0d after 64 cycles, expected 5", bus_if.pos);
      end
      repeat (2) cycle();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus_if.pos !== 3'd0 || bus_if.tick !== 1'b0 || bus_if.paused !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: pos=%0d tick=%0b paused=%0b, expected 0 0 0",
                  bus_if.pos, bus_if.tick, bus_if.paused);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (bus_if.tick === 1'b1) begin first = i; break; end
      end
      checks++;
      if (first != BT || bus_if.pos !== 3'd1) begin
         errors++;
         $display("FAIL post_reset_first: cyc=%0d pos=%0d, expected %0d 1", first, bus_if.pos, BT);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      logic [2:0] got;
      exp_q.delete();
      for (int i = 1; i <= 500; i++) begin
         if ($urandom_range(0, 19) == 0) bus_if.pause = ~bus_if.pause;
         if ($urandom_range(0, 39) == 0) bus_if.speed = 2'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) bus_if.dir = 1'($urandom_range(0, 1));
         if (hold == 0) begin
            bus_if.step_n = ~bus_if.step_n;
            hold = $urandom_range(1, 2 * DB);
         end
         hold--;
         cycle();
         checks++;
         if (bus_if.pos !== m_pos || bus_if.tick !== m_tick || bus_if.paused !== m_paused) begin
            errors++;
            $display("FAIL random_model cyc %0d: pos=%0d tick=%0b paused=%0b, expected %0d %0b %0b",
                     i, bus_if.pos, bus_if.tick, bus_if.paused, m_pos, m_tick, m_paused);
         end
         if (bus_if.tick === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL random_sb cyc %0d: tick with pos=%0d, expected no tick", i, bus_if.pos);
            end else begin
               got = exp_q.pop_front();
               if (bus_if.pos !== got) begin
                  errors++;
                  $display("FAIL random_sb cyc %0d: pos=%0d, expected %0d", i, bus_if.pos, got);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_sb_left: %0d ticks missing, expected 0", exp_q.size());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_free_run();
      test_speed_dir();
      test_step();
      test_step_unpaused();
      test_pause_release();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/controle_rolagem.md
Name: controle_rolagem

Overview:
- Upstream scroll controller for the 8-digit HEX sign; replaces the bare divider plus free-running position counter.
- Produces the 3-bit scroll position consumed by the per-digit decoders.
- Adds a selectable scroll speed, scroll direction, pause, and single-step from a debounced push-button.
- Runs entirely on CLOCK_50; uses a clock-enable tick, not a derived clock.

Parameters:
- BASE_TICKS, 12500000, CLOCK_50 cycles in the fastest scroll period (0.25 s).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new key level (20 ms).
- POS_MAX, 7, last position index; position wraps between 0 and POS_MAX.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (driven from SW[10]).
- speed  input  2  scroll period select: period = BASE_TICKS << speed (0.25/0.5/1/2 s).
- dir  input  1  0 = position increments, 1 = position decrements.
- pause  input  1  1 = automatic scrolling halted.
- step_n  input  1  raw push-button, active-low, asynchronous to CLOCK_50.
- pos  output  3  current scroll position, 0..POS_MAX.
- tick  output  1  one-cycle pulse, high in the same cycle pos takes its new value.
- paused  output  1  registered copy of pause.

Behaviour:
- Reset (reset=0, asynchronous):
  - pos=0, tick=0, paused=0, prescaler=0.
  - Synchroniser flops=1; debounced key state=1 (released); debounce counter=0.
  - Release of reset is synchronous to the next CLOCK_50 edge.
- Prescaler:
  - Counts 0..(BASE_TICKS<<speed)-1; width sized for BASE_TICKS*8.
  - At terminal count with pause=0: prescaler->0 and auto-advance asserted.
  - speed is registered. When the registered speed differs from its previous value, the prescaler clears to 0 that cycle, with no advance. The new period is measured from that clear.
  - While pause=1, the prescaler is held at 0. After pause falls, the first advance occurs a full period later.
- Key path:
  - step_n passes through a 2-FF synchroniser.
  - Debouncer counter increments while the synchronised level differs from the debounced state, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state toggles to the synchronised level and the counter clears.
  - A 1->0 transition of the debounced state is a step event: one cycle wide, registered.
  - Step events are honoured only when pause=1; otherwise they are discarded, never queued.
- Advance:
  - Advance = auto-advance OR honoured step event.
  - dir=0: pos = (pos==POS_MAX) ? 0 : pos+1.
  - dir=1: pos = (pos==0) ? POS_MAX : pos-1.
  - dir is sampled at the advance edge only; changing dir does not disturb the prescaler.
  - tick is registered: high exactly the cycle after the advance condition, aligned with the new pos.
- Simultaneous events:
  - Auto-advance and step cannot coincide, because pause gates them mutually exclusively.
  - Speed change on the same cycle as terminal count: the clear wins and no advance occurs.
- Latency:
  - Key press to pos change = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) + 1 (pos register) cycles.
- Bounce rejection: any glitch shorter than DEBOUNCE_CYCLES consecutive cycles leaves the debounced state unchanged.

Test Plan:
1. Free-run with BASE_TICKS=4, speed=0, dir=0, pause=0 -> pos steps 0,1,...,7,0 every 4 cycles; tick high 1 cycle per step; 8 ticks per 32 cycles.
2. speed=2, dir=1 from pos=0 (BASE_TICKS=4) -> first advance 16 cycles after release, pos=7 then 6; switching speed to 0 mid-period -> next advance exactly 4 cycles after the switch.
3. pause=1 with step_n pulsed low for DEBOUNCE_CYCLES+5 cycles (DEBOUNCE_CYCLES=8) -> exactly one advance, pos+1, single tick. A 5-cycle glitch -> no change.
4. pause=0 with a valid step_n press -> pos follows the prescaler only, with no extra advance; press held through pause rising -> no advance until a new falling edge.
5. reset pulsed low mid-period at pos=5 with prescaler nonzero -> outputs immediately pos=0, tick=0, paused=0. First advance occurs BASE_TICKS cycles after release.
6. Pause released -> first advance exactly BASE_TICKS<<speed cycles after pause falls; dir toggled 1 cycle before terminal count -> that advance uses the new direction.
